// File: rtl/cacheline_arbiter.sv
// Shares one cacheline-wide memory port between the icache and the dcache.
// Serves one whole line transaction at a time; ties alternate between the two requesters.
module cacheline_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_I = 3'd1;
  localparam logic [2:0] SERVE_D = 3'd2;
  localparam logic [2:0] RESP_I  = 3'd3;
  localparam logic [2:0] RESP_D  = 3'd4;

  logic [2:0] state;
  logic       last_grant_d;
  logic       i_pending;
  logic       d_pending;
  logic       grant_d;
  logic       grant_i;

  assign i_pending = i_read;
  assign d_pending = d_read | d_write;
  // On a tie the dcache wins unless it was the last one served.
  assign grant_d   = d_pending & (~i_pending | ~last_grant_d);
  assign grant_i   = i_pending & ~grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A write-back wins over a read if both are raised together.
            mem_address  <= d_address;
            mem_wdata    <= d_wdata;
            mem_write    <= d_write;
            mem_read     <= ~d_write;
            last_grant_d <= 1'b1;
            state        <= SERVE_D;
          end else if (grant_i) begin
            mem_address  <= i_address;
            mem_read     <= 1'b1;
            mem_write    <= 1'b0;
            last_grant_d <= 1'b0;
            state        <= SERVE_I;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            i_rdata  <= mem_rdata;
            mem_read <= 1'b0;
            i_resp   <= 1'b1;
            state    <= RESP_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            if (mem_read) d_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_resp    <= 1'b1;
            state     <= RESP_D;
          end
        end
        RESP_I, RESP_D: state <= IDLE;
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter; the bench acts as the memory
// and both caches, with expected values written out by hand.
module tb_cacheline_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  localparam logic [LW-1:0] LINE_A = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] LINE_B = {8{32'hB0B0_0002}};
  localparam logic [LW-1:0] LINE_C = {8{32'hC3C3_0003}};
  localparam logic [LW-1:0] LINE_D = {8{32'hD4D4_0004}};
  localparam logic [LW-1:0] LINE_E = {8{32'hE5E5_0005}};
  localparam logic [LW-1:0] LINE_F = {8{32'hF6F6_0006}};
  localparam logic [LW-1:0] LINE_G = {8{32'h1717_0007}};
  localparam logic [LW-1:0] LINE_X = {8{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  int checks = 0;
  int errors = 0;
  int i_pulses = 0;
  int d_pulses = 0;
  int viol = 0;
  int waited;
  logic [AW-1:0] cap_addr;
  logic          cap_rd, cap_wr;
  logic [LW-1:0] cap_wdata;

  cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_resp) i_pulses++;
    if (d_resp) d_pulses++;
    if (i_resp && d_resp) viol++;
    if (mem_read && mem_write) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required end before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Acts as memory: waits for a request, records it, answers lat cycles later.
  // Returns at the negedge inside the RESP cycle.
  task automatic run_mem(input int lat, input logic [LW-1:0] rdata);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!(mem_read || mem_write)) begin
      chk("mem_req_timeout", 0, 1);
      return;
    end
    cap_addr  = mem_address;
    cap_rd    = mem_read;
    cap_wr    = mem_write;
    cap_wdata = mem_wdata;
    repeat (lat - 1) @(negedge clk);
    chk("addr_stable", mem_address, cap_addr);
    mem_rdata = rdata;
    mem_resp  = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_i_rdata", i_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lone icache read, memory answers 3 cycles in.
    i_read = 1; i_address = 32'h0000_1040;
    run_mem(3, LINE_A);
    chk("i_grant_latency", waited, 1);
    chk("i_mem_address", cap_addr, 32'h0000_1040);
    chk("i_op_read", cap_rd, 1);
    chk("i_op_write", cap_wr, 0);
    chk("i_resp_high", i_resp, 1);
    chk("i_rdata", i_rdata, LINE_A);
    chk("i_no_d_resp", d_resp, 0);
    i_read = 0;
    @(negedge clk);
    chk("i_resp_one_cycle", i_resp, 0);
    chk("i_pulse_count", i_pulses, 1);

    // dcache write-back.
    d_write = 1; d_address = 32'h8000_0020; d_wdata = LINE_B;
    run_mem(2, LINE_X);
    chk("dw_mem_address", cap_addr, 32'h8000_0020);
    chk("dw_op_write", cap_wr, 1);
    chk("dw_op_read", cap_rd, 0);
    chk("dw_wdata", cap_wdata, LINE_B);
    chk("dw_d_resp", d_resp, 1);
    chk("dw_d_rdata_kept", d_rdata, 0);
    chk("dw_mem_write_dropped", mem_write, 0);
    d_write = 0;
    @(negedge clk);
    chk("dw_resp_one_cycle", d_resp, 0);

    // Simultaneous requests right after reset: D first, then I after one idle cycle.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_read = 1; i_address = 32'h0000_2000;
    d_read = 1; d_address = 32'h0000_3000;
    run_mem(1, LINE_C);
    chk("tie_first_addr", cap_addr, 32'h0000_3000);
    chk("tie_first_d_resp", d_resp, 1);
    chk("tie_first_no_i_resp", i_resp, 0);
    chk("tie_d_rdata", d_rdata, LINE_C);
    d_read = 0;
    run_mem(1, LINE_D);
    chk("tie_turnaround", waited, 2);
    chk("tie_second_addr", cap_addr, 32'h0000_2000);
    chk("tie_second_i_resp", i_resp, 1);
    chk("tie_i_rdata", i_rdata, LINE_D);
    i_read = 0;
    repeat (3) @(negedge clk);
    chk("tie_no_third_read", mem_read, 0);
    chk("tie_no_third_write", mem_write, 0);

    // Fairness: both requesters keep asking for six transactions.
    i_read = 1; i_address = 32'h0000_4400;
    d_read = 1; d_address = 32'h0000_5500;
    for (int k = 0; k < 6; k++) begin
      run_mem(1, LINE_E);
      chk($sformatf("fair_addr_%0d", k), cap_addr,
          (k % 2 == 0) ? 32'h0000_5500 : 32'h0000_4400);
      chk($sformatf("fair_wait_%0d", k), waited, (k == 0) ? 1 : 2);
      if (k == 5) begin
        i_read = 0;
        d_read = 0;
      end
    end
    @(negedge clk);

    // Reset in the middle of a write-back.
    d_write = 1; d_address = 32'h0000_6600; d_wdata = LINE_F;
    @(negedge clk);
    chk("mid_rst_serving", mem_write, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_d_resp", d_resp, 0);
    chk("mid_rst_mem_address", mem_address, 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    rst = 1'b1; d_write = 0;
    mem_rdata = LINE_X; mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("stray_d_resp", d_resp, 0);
    chk("stray_mem_read", mem_read, 0);
    @(negedge clk);
    chk("stray_d_resp_late", d_resp, 0);
    chk("stray_i_resp_late", i_resp, 0);

    // Illegal d_read + d_write: behaves as a write, d_rdata untouched.
    d_read = 1; d_address = 32'h0000_7700;
    run_mem(1, LINE_E);
    chk("prep_d_rdata", d_rdata, LINE_E);
    d_read = 0;
    @(negedge clk);
    d_read = 1; d_write = 1; d_address = 32'h0000_7740; d_wdata = LINE_F;
    run_mem(1, LINE_G);
    chk("ill_op_write", cap_wr, 1);
    chk("ill_op_read", cap_rd, 0);
    chk("ill_wdata", cap_wdata, LINE_F);
    chk("ill_d_resp", d_resp, 1);
    chk("ill_d_rdata_kept", d_rdata, LINE_E);
    d_read = 0; d_write = 0;
    repeat (2) @(negedge clk);

    chk("total_i_pulses", i_pulses, 5);
    chk("total_d_pulses", d_pulses, 7);
    chk("mutual_exclusion", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Arbitrates the single cacheline-wide physical-memory port between the instruction cache (IF-stage misses) and the data cache (MEM-stage misses and write-backs). Each requester holds a request until it receives a one-cycle response. The arbiter serves one whole line transaction at a time through a registered FSM and uses alternating priority on ties, so neither pipeline stage can be starved.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, byte address width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset; 0 at a rising edge resets the block
- i_read  in  1  icache line-read request; held until i_resp
- i_address  in  ADDR_WIDTH  icache line address
- i_rdata  out  LINE_WIDTH  line returned to icache; valid while i_resp=1
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line-read request; held until d_resp
- d_write  in  1  dcache line write-back request; held until d_resp
- d_address  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache write-back data
- d_rdata  out  LINE_WIDTH  line returned to dcache; valid while d_resp=1
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  read request to memory; held until mem_resp
- mem_write  out  1  write request to memory; held until mem_resp
- mem_address  out  ADDR_WIDTH  registered transaction address
- mem_wdata  out  LINE_WIDTH  registered write data
- mem_rdata  in  LINE_WIDTH  memory read data; valid with mem_resp
- mem_resp  in  1  memory completion pulse

## Operation
- States:
  - IDLE
  - SERVE_I: read only.
  - SERVE_D: read or write.
  - RESP_I
  - RESP_D
- All outputs are registered. Reset values:
  - State = IDLE.
  - mem_read = mem_write = 0.
  - i_resp = d_resp = 0.
  - mem_address, mem_wdata, i_rdata, d_rdata = 0.
  - last_grant = I.
- d_pending = d_read | d_write. i_pending = i_read.
- Decisions in IDLE:
  - Only i_pending: go to SERVE_I.
  - Only d_pending: go to SERVE_D.
  - Both pending: go to SERVE_D unless last_grant = D, in which case go to SERVE_I.
  - Neither pending: stay in IDLE.
- At grant:
  - Latch the requester's address into mem_address. For D, also latch d_wdata into mem_wdata.
  - Latch the operation: d_write takes precedence if d_read and d_write are both 1. That combination is illegal, but the behaviour is defined.
  - Update last_grant.
- In SERVE_x:
  - Hold mem_read or mem_write at 1 and keep the address and data stable.
  - Ignore changes on requester inputs.
  - On mem_resp = 1, capture mem_rdata into x_rdata (reads only), drop mem_read/mem_write, and go to RESP_x.
- RESP_x:
  - x_resp = 1 for exactly one cycle, then go to IDLE.
  - The other requester's pending request waits and is evaluated in IDLE.
- The requester must deassert its request in the cycle after x_resp. The arbiter does not re-grant in that cycle, because the request is sampled in IDLE one cycle later.
- mem_resp outside SERVE_* is ignored.
- x_rdata holds its value until the next read for that requester.
- Reset during any state returns the block to IDLE at the next edge with all outputs at their reset values. The in-flight transaction is abandoned and no x_resp is issued.

## Timing
- Request sampled in IDLE at edge 0. SERVE_x with mem_* asserted is visible from edge 1.
- mem_resp at edge k leads to RESP_x at edge k+1, with x_resp = 1 and rdata valid during that cycle. IDLE follows at edge k+2.
- Minimum request-to-resp latency: 2 cycles, when mem_resp arrives in the first SERVE cycle.
- Back-to-back grants: a new grant can occur at the edge ending the first IDLE cycle after RESP. Turnaround is 1 IDLE cycle.
- mem_read and mem_write are never both 1. Neither is asserted outside SERVE_*.
- i_resp and d_resp are never both 1 in the same cycle.

## Test plan
- Lone I read:
  - Stimulus: i_read=1, i_address=0x0000_1040. Memory answers 3 cycles after mem_read with mem_rdata=LINE_A.
  - Required: mem_read=1 with mem_address=0x0000_1040 from cycle 1. i_resp=1 exactly once with i_rdata=LINE_A. d_resp stays 0.
- D write-back:
  - Stimulus: d_write=1, d_address=0x8000_0020, d_wdata=LINE_B.
  - Required: mem_write=1, mem_wdata=LINE_B, mem_read=0. d_resp pulses once, 1 cycle after mem_resp.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read asserted together, both held until their own resp.
  - Required: D is served first and I second. Exactly 2 memory transactions occur, with 1 IDLE cycle between them.
- Fairness:
  - Stimulus: both requesters re-request immediately after every resp, for 6 transactions.
  - Required: grant order D, I, D, I, D, I. No requester waits for more than one other transaction.
- Reset mid-transaction:
  - Stimulus: drop rst to 0 during SERVE_D, before mem_resp.
  - Required: next edge gives IDLE, mem_write=0, d_resp=0. A later stray mem_resp is ignored.
- Illegal d_read and d_write together:
  - Stimulus: d_read=1 and d_write=1 in the same cycle.
  - Required: a write transaction is performed and d_rdata is unchanged.
